// File: rtl/dds_pkg.sv
// Shared constants for the DDS core: default widths, reset tuning word,
// quadrant encoding and FTW commit-mode encoding.
package dds_pkg;

  localparam int ACC_W_DEFAULT  = 32;
  localparam int ADDR_W_DEFAULT = 10;

  // Roughly 1 kHz out of a 100 MHz clock with a 32-bit accumulator
  localparam logic [31:0] FTW_DEFAULT = 32'd42950;

  // Phase quadrant encoding; bit 1 set means the sine is negative,
  // bit 0 set means the quarter-wave table is read backwards
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // FTW update modes
  localparam logic FTW_IMMEDIATE = 1'b0;
  localparam logic FTW_ON_WRAP   = 1'b1;

endpackage

// File: rtl/dds_phase_accum_if.sv
// Control and output bundle of the phase accumulator. The master side
// drives tuning/offset controls and reads the ROM address stream; the
// slave side is the accumulator itself.
interface dds_phase_accum_if #(
  parameter int ACC_W  = dds_pkg::ACC_W_DEFAULT,
  parameter int ADDR_W = dds_pkg::ADDR_W_DEFAULT
);

  logic              en;
  logic [ACC_W-1:0]  ftw_in;
  logic              ftw_load;
  logic              ftw_mode;
  logic              sync_clr;
  logic [ACC_W-1:0]  phase_off;

  logic [ADDR_W-3:0] lut_addr;
  logic [1:0]        quadrant;
  logic              neg;
  logic              addr_valid;
  logic              wrap;
  logic              ftw_pending;

  modport master (
    output en, ftw_in, ftw_load, ftw_mode, sync_clr, phase_off,
    input  lut_addr, quadrant, neg, addr_valid, wrap, ftw_pending
  );

  modport slave (
    input  en, ftw_in, ftw_load, ftw_mode, sync_clr, phase_off,
    output lut_addr, quadrant, neg, addr_valid, wrap, ftw_pending
  );

endinterface

// File: rtl/dds_quarter_fold.sv
// Folds a full-wave phase word into a quarter-wave ROM index plus the
// quadrant and sign bits. Purely combinational so the sine and cosine
// channels can each register it wherever their pipeline needs.
module dds_quarter_fold #(
  parameter int ACC_W  = dds_pkg::ACC_W_DEFAULT,
  parameter int ADDR_W = dds_pkg::ADDR_W_DEFAULT
) (
  input  logic [ACC_W-1:0]  phase_i,
  output logic [ADDR_W-3:0] lut_addr_o,
  output logic [1:0]        quadrant_o,
  output logic              neg_o
);

  logic [ADDR_W-1:0] top;
  logic [ADDR_W-3:0] idx;

  // Fractional phase bits below the ROM resolution are deliberately dropped
  logic unusedLowBits;
  assign unusedLowBits = ^phase_i[ACC_W-ADDR_W-1:0];

  assign top        = phase_i[ACC_W-1 -: ADDR_W];
  assign quadrant_o = top[ADDR_W-1:ADDR_W-2];
  assign idx        = top[ADDR_W-3:0];

  // Odd quadrants walk the quarter-wave table backwards
  assign lut_addr_o = quadrant_o[0] ? ~idx : idx;

  // Second half of the period is the mirrored negative lobe
  assign neg_o = quadrant_o[1];

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: integrates the tuning word, adds a resynchronised
// phase offset and folds the sum into a quarter-wave ROM address.
// Pipeline: A (accumulator) -> B (offset add) -> C (registered fold).
module dds_phase_accum #(
  parameter int ACC_W  = dds_pkg::ACC_W_DEFAULT,
  parameter int ADDR_W = dds_pkg::ADDR_W_DEFAULT,
  parameter logic [ACC_W-1:0] FTW_DEFAULT = dds_pkg::FTW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  dds_phase_accum_if.slave bus
);

  import dds_pkg::*;

  // Stage A state
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  ftwActive_q, ftwActive_d;
  logic [ACC_W-1:0]  ftwShadow_q, ftwShadow_d;
  logic              pending_q, pending_d;
  logic              carry_q;

  // Offset resynchroniser
  logic [ACC_W-1:0]  offQ1_q, offQ2_q, offUsed_q;

  // Stage B
  logic [ACC_W-1:0]  ph_q;
  logic              wrapB_q;

  // Stage C
  logic [ADDR_W-3:0] lutAddr_q;
  logic [1:0]        quadrant_q;
  logic              neg_q;
  logic              wrap_q;

  // addr_valid delay line
  logic              enD1_q, enD2_q;

  logic [ACC_W:0]    sum;
  logic              carryEvt;
  logic [ADDR_W-3:0] foldLut;
  logic [1:0]        foldQuad;
  logic              foldNeg;

  assign sum      = {1'b0, acc_q} + {1'b0, ftwActive_q};
  assign carryEvt = bus.en && !bus.sync_clr && sum[ACC_W];

  // Next accumulator and tuning-word state; a fresh load always beats a commit
  always_comb begin
    acc_d       = acc_q;
    ftwActive_d = ftwActive_q;
    ftwShadow_d = ftwShadow_q;
    pending_d   = pending_q;

    if (bus.sync_clr) begin
      acc_d = '0;
    end else if (bus.en) begin
      acc_d = sum[ACC_W-1:0];
    end

    if (bus.ftw_load) begin
      ftwShadow_d = bus.ftw_in;
      if (bus.ftw_mode == FTW_ON_WRAP) begin
        pending_d = 1'b1;
      end else begin
        ftwActive_d = bus.ftw_in;
        pending_d   = 1'b0;
      end
    end else if (pending_q && (bus.sync_clr || carryEvt)) begin
      ftwActive_d = ftwShadow_q;
      pending_d   = 1'b0;
    end
  end

  // Stage A registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      ftwActive_q <= FTW_DEFAULT;
      ftwShadow_q <= FTW_DEFAULT;
      pending_q   <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ftwActive_q <= ftwActive_d;
      ftwShadow_q <= ftwShadow_d;
      pending_q   <= pending_d;
      carry_q     <= carryEvt;
    end
  end

  // Two-flop resync of the offset word; only adopt it once two samples agree
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offQ1_q   <= '0;
      offQ2_q   <= '0;
      offUsed_q <= '0;
    end else begin
      offQ1_q <= bus.phase_off;
      offQ2_q <= offQ1_q;
      if (offQ1_q == offQ2_q) begin
        offUsed_q <= offQ2_q;
      end
    end
  end

  // Stage B: apply offset every clock so offset changes show even when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q    <= '0;
      wrapB_q <= 1'b0;
    end else begin
      ph_q    <= acc_q + offUsed_q;
      wrapB_q <= carry_q;
    end
  end

  dds_quarter_fold #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W)
  ) uFold (
    .phase_i    (ph_q),
    .lut_addr_o (foldLut),
    .quadrant_o (foldQuad),
    .neg_o      (foldNeg)
  );

  // Stage C: register the folded address alongside the aligned wrap flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lutAddr_q  <= '0;
      quadrant_q <= 2'b00;
      neg_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      lutAddr_q  <= foldLut;
      quadrant_q <= foldQuad;
      neg_q      <= foldNeg;
      wrap_q     <= wrapB_q;
    end
  end

  // Valid tracks enable through a fixed two-clock delay, independent of clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enD1_q <= 1'b0;
      enD2_q <= 1'b0;
    end else begin
      enD1_q <= bus.en;
      enD2_q <= enD1_q;
    end
  end

  assign bus.lut_addr    = lutAddr_q;
  assign bus.quadrant    = quadrant_q;
  assign bus.neg         = neg_q;
  assign bus.addr_valid  = enD2_q;
  assign bus.wrap        = wrap_q;
  assign bus.ftw_pending = pending_q;

endmodule

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
Phase accumulator stage of the DDS core. It sits between the phase-offset register block, which supplies the 32-bit phase_off word, and the quarter-wave sine ROM, which it feeds.
- Accumulates a frequency tuning word (FTW) every enabled clock.
- Adds the resynchronised phase offset.
- Folds the result into a quarter-wave ROM address plus quadrant/sign bits.
- Supports immediate and phase-continuous (commit-on-wrap) FTW updates.

Parameters:
ACC_W, 32, accumulator and FTW width
ADDR_W, 10, full-wave phase resolution in bits; ROM index width is ADDR_W-2
FTW_DEFAULT, 32'd42950, FTW after reset (about 1 kHz at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
en  in  1  accumulate enable
ftw_in  in  ACC_W  new tuning word
ftw_load  in  1  single-cycle strobe, captures ftw_in
ftw_mode  in  1  0 = commit immediately, 1 = commit on next accumulator wrap
sync_clr  in  1  synchronous accumulator clear
phase_off  in  ACC_W  phase offset from the phase-offset block (asynchronous to clk)
lut_addr  out  ADDR_W-2  quarter-wave ROM index
quadrant  out  2  phase quadrant 0..3
neg  out  1  output sample must be negated (quadrant[1])
addr_valid  out  1  outputs valid
wrap  out  1  one-cycle pulse, aligned with the first post-wrap output
ftw_pending  out  1  committed-on-wrap FTW is waiting

Behaviour:
- Reset (async, reset=0):
  - acc=0; ftw_active=ftw_shadow=FTW_DEFAULT; pending=0.
  - Offset sync registers=0; all pipeline registers=0.
  - Outputs lut_addr=0, quadrant=0, neg=0, addr_valid=0, wrap=0, ftw_pending=0.
  - Takes effect immediately, including mid-operation.
- Stage A (accumulator):
  - Priority is sync_clr > en. sync_clr: acc<=0.
  - If pending, sync_clr also commits: ftw_active<=ftw_shadow, pending<=0.
  - Else if en: acc<=acc+ftw_active, modulo 2^ACC_W. Carry-out is the wrap event.
  - en=0: acc holds.
- FTW load:
  - ftw_load=1 captures ftw_in into ftw_shadow.
  - ftw_mode=0: ftw_active<=ftw_in at the same edge; the first increment using it is on the next enabled edge. Any pending flag is cleared.
  - ftw_mode=1: pending<=1. At the first enabled edge whose add carries out, ftw_active<=ftw_shadow and pending<=0. That wrapping add itself still uses the old FTW.
  - Load and carry in the same cycle, mode 1: the load wins. Shadow takes the new word, pending stays 1, ftw_active is unchanged, and the commit happens on the next wrap.
  - ftw_pending = pending register.
- Offset capture (CDC):
  - phase_off passes through two flops, q1 then q2.
  - off_used<=q2 only when q1==q2; otherwise it holds.
  - Minimum latency from a stable phase_off to off_used is 3 clocks.
- Stage B: ph<=acc+off_used, modulo 2^ACC_W, registered every clock regardless of en.
- Stage C (fold), registered:
  - top = ph[ACC_W-1 -: ADDR_W]; quadrant=top[ADDR_W-1:ADDR_W-2].
  - idx=top[ADDR_W-3:0].
  - lut_addr = quadrant[0] ? ~idx : idx.
  - neg=quadrant[1].
- Latency: an acc value appears on lut_addr 2 clocks after it is registered.
- addr_valid: en delayed through a 2-stage shift register, so it follows en with a 2-clock delay. sync_clr does not drop it.
- wrap: carry flag delayed so it is asserted in the same cycle as the output derived from the first post-wrap acc value. It never asserts when en=0 and is not generated by sync_clr.
- FTW=0: acc frozen, no wrap, and pending never commits except via sync_clr or a mode-0 load.

Decomposition:
- Package dds_pkg holds:
  - ACC_W/ADDR_W defaults and FTW_DEFAULT.
  - Quadrant encoding constants Q0..Q3.
  - FTW mode constants FTW_IMMEDIATE=0 and FTW_ON_WRAP=1.
- One sub-module: dds_quarter_fold, the combinational Stage C fold used by the registered Stage C. It is shared later with the cosine channel.

Test Plan:
- Sweep with FTW=2^22, mode 0:
  - Stimulus: after reset, pulse sync_clr, then en=1 continuously.
  - Response: lut_addr runs 0..255 with quadrant 0, then 255..0 with quadrant 1, then 0..255 with neg=1 (quadrant 2), and so on.
  - wrap pulses every 1024 clocks; addr_valid rises 2 clocks after en.
- Offset capture:
  - Stimulus: FTW=0, acc=0; drive phase_off=32'h4000_0000 and hold it.
  - Response: quadrant becomes 1 and lut_addr becomes 255 exactly 5 clocks after the change (3 for capture, 2 for pipeline).
  - Stimulus: toggle phase_off every clock.
  - Response: off_used never changes.
- Phase-continuous load:
  - Stimulus: FTW=2^22; at acc=32'h8000_0000 load 2^23 with mode 1.
  - Response: ftw_pending=1 for 512 clocks; the step becomes 2^23 only after the wrap; wrap aligns with lut_addr=0, quadrant 0.
- Load colliding with wrap:
  - Stimulus: mode-1 load of 2^20 issued on the wrapping edge.
  - Response: pending stays 1 and the step is unchanged until the following wrap.
- sync_clr with pending:
  - Stimulus: pending=1, pulse sync_clr.
  - Response: acc=0, ftw_active=shadow, ftw_pending=0, addr_valid still 1, no wrap pulse.
- Async reset mid-sweep:
  - Stimulus: assert reset between clock edges.
  - Response: all outputs read 0 immediately; after release the FTW is 42950 and addr_valid returns 2 clocks after en.
